usrt_rx_ctrl: RTL and testbench
===============================

USRT_RX_CTRL -- requirements
Module: usrt_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 16, meaning idle baud ticks with unread data before the timeout flag sets.
REQ-002 SHALL have port i_Pclk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Bclk  in  1  baud tick, one i_Pclk cycle wide per bit period.
REQ-005 SHALL have port i_Enable  in  1  receiver enable.
REQ-006 SHALL have port i_Rx_Serial  in  1  raw serial line, idle high.
REQ-007 SHALL have port i_Parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 SHALL have port i_Par_Ok  in  1  parity checker verdict, valid one cycle after o_Frame_Done.
REQ-009 SHALL have port i_Full  in  1  data register full.
REQ-010 SHALL have port i_Clear  in  1  one-cycle pulse clearing sticky status flags.
REQ-011 SHALL have ports o_Bit and o_Shift  out  1 each  synchronized sample value and shift strobe to the shift register.
REQ-012 SHALL have ports o_Frame_Done and o_Push  out  1 each  one-cycle pulses to the parity checker and data register.
REQ-013 SHALL have ports o_Status  out  5  {timeout, overrun, framing, parity, busy} and o_Irq  out  1.

Function
REQ-014 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 SHALL implement FSM IDLE, DATA, CHECK, VERDICT.
REQ-016 IDLE: on i_Bclk with i_Enable=1 and a synchronized low line, SHALL latch i_Parity, load the bit count with 1, pulse o_Shift, and enter DATA.
REQ-017 DATA: on each i_Bclk, SHALL pulse o_Shift and increment the count; frame length is 11 bits with parity and 10 bits with parity none.
REQ-018 DATA: when the final (stop) bit is sampled, SHALL record framing error if it is 0 and enter CHECK.
REQ-019 o_Shift/o_Bit SHALL be registered and asserted exactly one i_Pclk cycle after the qualifying i_Bclk.
REQ-020 CHECK: SHALL pulse o_Frame_Done for one cycle and then enter VERDICT.
REQ-021 VERDICT: SHALL evaluate i_Par_Ok, ignoring it in parity-none mode, and return to IDLE the same cycle.
- parity bad: set parity flag, no push.
- framing bad: set framing flag, no push; both flags may set together.
- valid with i_Full=1: set overrun, no push.
- valid with i_Full=0: o_Push pulses once.
REQ-022 i_Enable low in any non-IDLE state SHALL abort to IDLE next cycle: no push, no flag change.
REQ-023 Status bits 4:1 SHALL be sticky until i_Clear; a set and i_Clear in the same cycle SHALL leave the flag set.
REQ-024 busy (bit 0) SHALL be 1 whenever state is not IDLE.
REQ-025 o_Irq SHALL be the registered OR of status bits 4:1 and i_Full.

Reset
REQ-026 i_Reset_n low SHALL immediately force IDLE, a zero count, all outputs 0, and o_Status=0; synchronizer flops SHALL reset to 1.
REQ-027 Reset mid-frame SHALL discard the frame with no push.

Configuration
REQ-028 With USRT_RX_TIMEOUT_EN defined, a counter SHALL count i_Bclk ticks in IDLE while i_Full=1.
- counter clears on start-bit detection or when i_Full=0.
- on reaching TIMEOUT_TICKS, status bit 4 sets, sticky.
REQ-029 Without USRT_RX_TIMEOUT_EN, no counter SHALL exist and status bit 4 SHALL be constant 0.

Structure
REQ-030 Package usrt_pkg SHALL hold the FSM state enum, parity mode encodings and status bit indices.
REQ-031 The synchronizer SHALL be sub-module usrt_sync2; all other logic is flat.

Verification
REQ-032 Even parity, frame 11'b10001101010 LSB first -> 11 o_Shift pulses, o_Frame_Done, i_Par_Ok=1 -> one o_Push, o_Status=0.
REQ-033 Even parity, frame 11'b11001101010, i_Par_Ok=0 -> no o_Push, o_Status[1]=1, o_Irq=1; i_Clear -> o_Status=0.
REQ-034 Odd parity, frame 11'b00010111010 (stop bit 0) -> no push, framing flag set.
REQ-035 Valid frame with i_Full=1 -> no push, overrun set; i_Enable dropped after bit 5 -> IDLE, busy=0, no flags.
REQ-036 Reset at bit 7 -> all outputs 0; with USRT_RX_TIMEOUT_EN, i_Full held for 16 idle ticks -> timeout flag set on tick 16, not earlier.

Source files
------------

// File: rtl/usrt_pkg.sv
// usrt_pkg: shared definitions for the USRT receive controller.
//   state_e      - receive FSM states
//   PAR_*        - parity mode encodings carried on i_Parity
//   STAT_*       - bit positions inside o_Status
//   FRAME_LEN_*  - frame lengths in bits (start + data + [parity] + stop)
package usrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_VERDICT = 2'd3
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int STAT_BUSY = 0;
  localparam int STAT_PAR  = 1;
  localparam int STAT_FRM  = 2;
  localparam int STAT_OVR  = 3;
  localparam int STAT_TMO  = 4;

  localparam logic [3:0] FRAME_LEN_PAR   = 4'd11;
  localparam logic [3:0] FRAME_LEN_NOPAR = 4'd10;

  // Mode 2'b11 is reserved and behaves like "none".
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/usrt_sync2.sv
// usrt_sync2: two-flop synchronizer for the asynchronous serial line.
//   i_Clk      - destination clock
//   i_Reset_n  - asynchronous active-low reset
//   i_D        - asynchronous input
//   o_Q        - synchronized output
module usrt_sync2 (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  // NOTE: both flops reset to 1 so a reset line reads as idle, not as a start bit.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two stages shift, not collapse into one.
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/usrt_rx_ctrl.sv
// usrt_rx_ctrl: receive control for a synchronous USRT.
// Samples the synchronized line on each baud tick, strobes the shift
// register, hands the frame to the parity checker and decides whether the
// byte is pushed into the data register or flagged.
//   i_Pclk, i_Reset_n      - clock, asynchronous active-low reset
//   i_Bclk                 - baud tick, one i_Pclk wide
//   i_Enable               - receiver enable; low aborts a frame in progress
//   i_Rx_Serial            - raw serial line, idle high
//   i_Parity               - 00 none, 01 even, 10 odd, 11 none
//   i_Par_Ok               - parity verdict, valid the cycle after o_Frame_Done
//   i_Full, i_Clear        - data register full, clear sticky status
//   o_Bit, o_Shift         - registered sample and shift strobe
//   o_Frame_Done, o_Push   - pulses to parity checker and data register
//   o_Status               - {timeout, overrun, framing, parity, busy}
//   o_Irq                  - registered OR of sticky flags and i_Full
// Optional feature: define USRT_RX_TIMEOUT_EN to add the idle timeout counter
// driving o_Status[4]; otherwise that bit is constant 0.
module usrt_rx_ctrl
  import usrt_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic       i_Pclk,
  input  logic       i_Reset_n,
  input  logic       i_Bclk,
  input  logic       i_Enable,
  input  logic       i_Rx_Serial,
  input  logic [1:0] i_Parity,
  input  logic       i_Par_Ok,
  input  logic       i_Full,
  input  logic       i_Clear,
  output logic       o_Bit,
  output logic       o_Shift,
  output logic       o_Frame_Done,
  output logic       o_Push,
  output logic [4:0] o_Status,
  output logic       o_Irq
);

  if (TIMEOUT_TICKS == 0) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be nonzero");
  end

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] par_mode_q, par_mode_d;
  logic       frm_err_q, frm_err_d;
  logic       shift_q, shift_d;
  logic       bit_q, bit_d;
  logic       par_flag_q, frm_flag_q, ovr_flag_q, irq_q;
  logic       tmo_flag;

  logic       rx_s;
  logic       start;
  logic       data_tick;
  logic       last_bit;
  logic [3:0] frame_len;
  logic       push, par_set, frm_set, ovr_set, frame_done;

  usrt_sync2 u_sync (
    .i_Clk     (i_Pclk),
    .i_Reset_n (i_Reset_n),
    .i_D       (i_Rx_Serial),
    .o_Q       (rx_s)
  );

  assign start     = (state_q == ST_IDLE) && i_Bclk && i_Enable && !rx_s;
  assign data_tick = (state_q == ST_DATA) && i_Bclk && i_Enable;
  assign frame_len = has_parity(par_mode_q) ? FRAME_LEN_PAR : FRAME_LEN_NOPAR;
  // The start bit already counts as bit 1, so the stop bit is sampled at len-1.
  assign last_bit  = (cnt_q == frame_len - 4'd1);

  // State register
  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a dropped enable aborts from any active state.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_DATA;
      ST_DATA: begin
        if (!i_Enable)                state_d = ST_IDLE;
        else if (i_Bclk && last_bit)  state_d = ST_CHECK;
      end
      ST_CHECK:   state_d = i_Enable ? ST_VERDICT : ST_IDLE;
      ST_VERDICT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: verdict is only acted on while still enabled.
  always_comb begin
    frame_done = 1'b0;
    push       = 1'b0;
    par_set    = 1'b0;
    frm_set    = 1'b0;
    ovr_set    = 1'b0;
    if (i_Enable) begin
      if (state_q == ST_CHECK) frame_done = 1'b1;
      if (state_q == ST_VERDICT) begin
        par_set = has_parity(par_mode_q) && !i_Par_Ok;
        frm_set = frm_err_q;
        ovr_set = !par_set && !frm_set && i_Full;
        push    = !par_set && !frm_set && !i_Full;
      end
    end
  end

  // Frame datapath: bit count, latched parity mode, framing error, strobes.
  always_comb begin
    cnt_d      = cnt_q;
    par_mode_d = par_mode_q;
    frm_err_d  = frm_err_q;
    shift_d    = 1'b0;
    bit_d      = bit_q;
    if (start) begin
      cnt_d      = 4'd1;
      par_mode_d = i_Parity;
      frm_err_d  = 1'b0;
      shift_d    = 1'b1;
      bit_d      = rx_s;
    end else if (data_tick) begin
      cnt_d   = cnt_q + 4'd1;
      shift_d = 1'b1;
      bit_d   = rx_s;
      if (last_bit) frm_err_d = !rx_s;
    end
    if (state_q != ST_IDLE && state_d == ST_IDLE) cnt_d = 4'd0;
  end

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q      <= 4'd0;
      par_mode_q <= PAR_NONE;
      frm_err_q  <= 1'b0;
      shift_q    <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      par_mode_q <= par_mode_d;
      frm_err_q  <= frm_err_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
    end
  end

  // Sticky flags: a set wins over a simultaneous clear.
  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      par_flag_q <= (par_flag_q && !i_Clear) || par_set;
      frm_flag_q <= (frm_flag_q && !i_Clear) || frm_set;
      ovr_flag_q <= (ovr_flag_q && !i_Clear) || ovr_set;
      irq_q      <= tmo_flag || ovr_flag_q || frm_flag_q || par_flag_q || i_Full;
    end
  end

`ifdef USRT_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_TICKS);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_set;
  logic             tmo_flag_q;

  // Counts idle ticks while unread data waits; saturates at TMO_MAX.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_set   = 1'b0;
    if (!i_Full || start) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_IDLE && i_Bclk && tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_set   = (tmo_cnt_q == TMO_MAX - 1'b1);
    end
  end

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= (tmo_flag_q && !i_Clear) || tmo_set;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  assign tmo_flag = 1'b0;
`endif

  assign o_Bit        = bit_q;
  assign o_Shift      = shift_q;
  assign o_Frame_Done = frame_done;
  assign o_Push       = push;
  assign o_Irq        = irq_q;

  assign o_Status[STAT_BUSY] = (state_q != ST_IDLE);
  assign o_Status[STAT_PAR]  = par_flag_q;
  assign o_Status[STAT_FRM]  = frm_flag_q;
  assign o_Status[STAT_OVR]  = ovr_flag_q;
  assign o_Status[STAT_TMO]  = tmo_flag;

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb_usrt_rx_ctrl: directed self-checking bench for usrt_rx_ctrl.
// Frames are sent LSB first; each bit is held for four i_Pclk cycles with
// the baud tick on the third so the synchronized line has settled.
module tb_usrt_rx_ctrl;

  logic       i_Pclk = 1'b0;
  logic       i_Reset_n;
  logic       i_Bclk;
  logic       i_Enable;
  logic       i_Rx_Serial;
  logic [1:0] i_Parity;
  logic       i_Par_Ok;
  logic       i_Full;
  logic       i_Clear;
  logic       o_Bit;
  logic       o_Shift;
  logic       o_Frame_Done;
  logic       o_Push;
  logic [4:0] o_Status;
  logic       o_Irq;

  int checks = 0;
  int errors = 0;

  int          shift_cnt = 0;
  int          push_cnt  = 0;
  int          done_cnt  = 0;
  logic [10:0] shift_log = '0;

  int base_shift, base_push, base_done;

  localparam logic [10:0] FRAME_A    = 11'b10001101010;
  localparam logic [10:0] FRAME_B    = 11'b11001101010;
  localparam logic [10:0] FRAME_C    = 11'b00010111010;
  localparam logic [10:0] FRAME_NONE = 11'b01010010110;

  always #5 i_Pclk = ~i_Pclk;

  usrt_rx_ctrl #(.TIMEOUT_TICKS(16)) dut (
    .i_Pclk       (i_Pclk),
    .i_Reset_n    (i_Reset_n),
    .i_Bclk       (i_Bclk),
    .i_Enable     (i_Enable),
    .i_Rx_Serial  (i_Rx_Serial),
    .i_Parity     (i_Parity),
    .i_Par_Ok     (i_Par_Ok),
    .i_Full       (i_Full),
    .i_Clear      (i_Clear),
    .o_Bit        (o_Bit),
    .o_Shift      (o_Shift),
    .o_Frame_Done (o_Frame_Done),
    .o_Push       (o_Push),
    .o_Status     (o_Status),
    .o_Irq        (o_Irq)
  );

  // Pulse monitor on the falling edge, away from the active edge.
  always @(negedge i_Pclk) begin
    if (o_Shift) begin
      shift_cnt = shift_cnt + 1;
      shift_log = {o_Bit, shift_log[10:1]};
    end
    if (o_Push)       push_cnt = push_cnt + 1;
    if (o_Frame_Done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bit(input logic b);
    i_Rx_Serial = b;
    step();
    step();
    i_Bclk = 1'b1;
    step();
    i_Bclk = 1'b0;
    step();
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  task automatic tick();
    i_Bclk = 1'b1;
    step();
    i_Bclk = 1'b0;
    step();
  endtask

  task automatic clear_pulse();
    i_Clear = 1'b1;
    step();
    i_Clear = 1'b0;
    idle(2);
  endtask

  task automatic snap();
    base_shift = shift_cnt;
    base_push  = push_cnt;
    base_done  = done_cnt;
  endtask

  initial begin
    i_Reset_n   = 1'b0;
    i_Bclk      = 1'b0;
    i_Enable    = 1'b1;
    i_Rx_Serial = 1'b1;
    i_Parity    = 2'b01;
    i_Par_Ok    = 1'b1;
    i_Full      = 1'b0;
    i_Clear     = 1'b0;
    idle(3);
    check("reset_status", o_Status, 5'b00000);
    check("reset_shift",  o_Shift,  1'b0);
    check("reset_push",   o_Push,   1'b0);
    check("reset_irq",    o_Irq,    1'b0);
    i_Reset_n = 1'b1;
    idle(3);

    // Good even-parity frame.
    snap();
    send_bits(FRAME_A, 5);
    check("busy_midframe", o_Status, 5'b00001);
    for (int i = 5; i < 11; i++) send_bit(FRAME_A[i]);
    idle(3);
    check("good_shifts", shift_cnt - base_shift, 11);
    check("good_bits",   shift_log, FRAME_A);
    check("good_done",   done_cnt - base_done, 1);
    check("good_push",   push_cnt - base_push, 1);
    check("good_status", o_Status, 5'b00000);
    check("good_irq",    o_Irq, 1'b0);

    // Bad parity verdict.
    snap();
    i_Par_Ok = 1'b0;
    send_bits(FRAME_B, 11);
    idle(3);
    check("par_push",   push_cnt - base_push, 0);
    check("par_status", o_Status, 5'b00010);
    check("par_irq",    o_Irq, 1'b1);
    clear_pulse();
    check("par_cleared", o_Status, 5'b00000);
    check("par_irq_off", o_Irq, 1'b0);

    // Bad parity again with i_Clear held across the verdict: set must win.
    send_bits(FRAME_B, 10);
    i_Rx_Serial = FRAME_B[10];
    step();
    step();
    i_Bclk = 1'b1;
    step();
    i_Bclk  = 1'b0;
    i_Clear = 1'b1;
    step();
    step();
    i_Clear = 1'b0;
    idle(2);
    check("set_beats_clear", o_Status, 5'b00010);
    clear_pulse();
    i_Par_Ok = 1'b1;

    // Odd parity, stop bit 0: framing error.
    snap();
    i_Parity = 2'b10;
    send_bits(FRAME_C, 11);
    i_Rx_Serial = 1'b1;
    idle(3);
    check("frm_push",   push_cnt - base_push, 0);
    check("frm_status", o_Status, 5'b00100);
    clear_pulse();
    check("frm_cleared", o_Status, 5'b00000);

    // Parity none: 10-bit frame, i_Par_Ok ignored.
    snap();
    i_Parity = 2'b00;
    i_Par_Ok = 1'b0;
    send_bits(FRAME_NONE, 10);
    idle(3);
    check("none_shifts", shift_cnt - base_shift, 10);
    check("none_bits",   shift_log[10:1], FRAME_NONE[9:0]);
    check("none_push",   push_cnt - base_push, 1);
    check("none_status", o_Status, 5'b00000);

    // Mode 11 behaves like none.
    snap();
    i_Parity = 2'b11;
    send_bits(FRAME_NONE, 10);
    idle(3);
    check("mode11_push",   push_cnt - base_push, 1);
    check("mode11_status", o_Status, 5'b00000);
    i_Par_Ok = 1'b1;
    i_Parity = 2'b01;

    // Valid frame while the data register is full: overrun.
    snap();
    i_Full = 1'b1;
    send_bits(FRAME_A, 11);
    idle(3);
    check("ovr_push",   push_cnt - base_push, 0);
    check("ovr_status", o_Status, 5'b01000);
    check("ovr_irq",    o_Irq, 1'b1);
    i_Full = 1'b0;
    clear_pulse();
    check("ovr_cleared", o_Status, 5'b00000);

    // Enable dropped after bit 5: abort, no push, no flags.
    snap();
    send_bits(FRAME_A, 6);
    check("abort_busy_before", o_Status, 5'b00001);
    i_Enable = 1'b0;
    step();
    check("abort_idle", o_Status, 5'b00000);
    i_Rx_Serial = 1'b1;
    idle(3);
    i_Enable = 1'b1;
    idle(3);
    check("abort_push",   push_cnt - base_push, 0);
    check("abort_done",   done_cnt - base_done, 0);
    check("abort_status", o_Status, 5'b00000);

    // Reset during bit 7 with i_Full raising o_Irq.
    snap();
    i_Full = 1'b1;
    idle(2);
    check("pre_reset_irq", o_Irq, 1'b1);
    send_bits(FRAME_A, 7);
    i_Rx_Serial = FRAME_A[7];
    step();
    i_Reset_n = 1'b0;
    #1;
    check("rst_status", o_Status, 5'b00000);
    check("rst_irq",    o_Irq, 1'b0);
    check("rst_shift",  o_Shift, 1'b0);
    check("rst_bit",    o_Bit, 1'b0);
    check("rst_done",   o_Frame_Done, 1'b0);
    check("rst_push",   o_Push, 1'b0);
    i_Full      = 1'b0;
    i_Rx_Serial = 1'b1;
    idle(2);
    i_Reset_n = 1'b1;
    idle(4);
    check("rst_no_push", push_cnt - base_push, 0);

    // Recovery after reset.
    snap();
    send_bits(FRAME_A, 11);
    idle(3);
    check("recover_push", push_cnt - base_push, 1);

    // Idle timeout: 16 ticks with unread data.
    i_Full = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("tmo_tick15", o_Status[4], 1'b0);
    tick();
`ifdef USRT_RX_TIMEOUT_EN
    check("tmo_tick16", o_Status[4], 1'b1);
`else
    check("tmo_disabled", o_Status[4], 1'b0);
`endif
    check("tmo_irq", o_Irq, 1'b1);
    i_Full = 1'b0;
    clear_pulse();
    check("tmo_cleared", o_Status, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
